mig_write_packer: RTL and testbench
===================================

// Module: mig_write_packer
// PURPOSE
//  Write-path stage feeding the MIG native app interface. Accepts write commands and a 32-bit
//  data stream from the core memory FIFOs, and packs them into 128-bit, beat-aligned, byte-masked
//  writes. Each beat is issued as one app_cmd WRITE plus one app_wdf beat. Reads are handled by a
//  separate unpacker and are never presented here.
// PARAMETERS
//  ADDR_WIDTH   28   MIG app_addr width (16-bit column units)
//  DATA_WIDTH   128  MIG beat width; DATA_WIDTH/WORD_WIDTH must be a power of 2
//  WORD_WIDTH   32   core write word width
// PORTS
//  clk                  in   1    UI clock; all logic on rising edge
//  reset_n              in   1    async, active-low reset
//  init_calib_complete  in   1    MIG calibration done
//  cmd_data             in   64   {word_addr[31:0], len_words[31:0]}
//  cmd_valid/cmd_ready  in/out 1  command handshake; transfer on valid&&ready
//  wr_data              in   32   write word
//  wr_valid/wr_ready    in/out 1  data handshake; transfer on valid&&ready
//  app_en/app_rdy       out/in 1  MIG command handshake
//  app_cmd              out  3    always CMD_WRITE (3'b000)
//  app_addr             out  28   beat address = {word_addr>>2, 3'b000}, truncated to ADDR_WIDTH
//  app_wdf_wren/app_wdf_rdy out/in 1  MIG write-data handshake
//  app_wdf_data         out  128  lane n = bits [32n+31:32n]
//  app_wdf_mask         out  16   1 = byte NOT written; lane n -> bits [4n+3:4n]
//  app_wdf_end          out  1    equals app_wdf_wren (one beat per burst)
//  busy                 out  1    command in progress
//  done                 out  1    one-cycle pulse when a command's last beat has been accepted
// BEHAVIOUR
//  Reset: all outputs 0 except app_wdf_mask=16'hFFFF; pack register cleared; state IDLE.
//  States:
//   IDLE: cmd_ready = init_calib_complete. On accept, latch addr/len.
//         len==0: pulse done next cycle, stay IDLE. Otherwise -> FILL.
//   FILL: wr_ready=1. Each accepted word writes lane addr[1:0] and clears its 4 mask bits;
//         addr++, remain--. Next state is ISSUE when the lane just written is 3 or remain hits 0.
//   ISSUE: wr_ready=0. app_en and app_wdf_wren assert together and are held independently until
//          their own rdy; flags cmd_ok/data_ok track each. A side is never re-issued after acceptance.
//          Leave ISSUE in the cycle both sides are accepted (same or different cycles).
//          If remain==0: done pulse, -> IDLE. Else: reload mask 16'hFFFF, -> FILL.
//  Latency: app_en is high in the cycle after the beat-completing word is accepted.
//  Best-case throughput: 1 beat per 5 cycles.
//  Unaligned start or end: unwritten lanes stay masked; data in masked lanes is don't-care
//   (drive 0).
//  Beat base captured at the first word of each beat; address arithmetic wraps modulo 2^ADDR_WIDTH
//   without error.
//  app_addr/app_wdf_data/app_wdf_mask are stable whenever app_en or app_wdf_wren is high.
//  init_calib_complete deasserting mid-command does not abort; it only gates new cmd accepts.
//  Async reset mid-operation discards any partial beat; no app_en/wren glitch after reset release.
//  busy = (state != IDLE).
// STRUCTURE
//  mig_pkg: APP_CMD_WRITE/APP_CMD_READ constants, state enum, mem_wcmd_t struct {addr, len}.
//  No sub-module: one FSM + pack register + address/remain counters (about 200 lines).
// TESTING
//  1 addr 0x100, len 8, words 1..8, rdys high -> app_addr 0x200 then 0x208, mask 16'h0000,
//    beat0 = {4,3,2,1}; one done pulse.
//  2 addr 0x103, len 2 -> beat0 app_addr 0x200, mask 16'h0FFF, lane3 = w0;
//    beat1 app_addr 0x208, mask 16'hFFF0, lane0 = w1.
//  3 app_rdy low 10 cycles, app_wdf_rdy high -> exactly 1 wren cycle; app_en held 11 cycles;
//    wr_ready 0 throughout.
//  4 len 0 -> done pulse 1 cycle after accept; no app_en or app_wdf_wren.
//  5 init_calib_complete=0 with cmd_valid=1 -> cmd_ready stays 0. Raise it -> accepted next cycle.
//  6 reset_n low after 2 of 4 words -> all outputs at reset values immediately; new command
//    afterwards packs from a clean mask.

Source files
------------

// File: rtl/mig_write_packer_pkg.sv
// Shared types and constants for the MIG write packer: app command codes,
// FSM state encoding and the latched write command.
package mig_write_packer_pkg;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ISSUE = 2'd2
    } wp_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
    } mem_wcmd_t;

endpackage

// File: rtl/mig_write_packer.sv
// Packs a 32-bit write word stream into 128-bit byte-masked MIG beats, one
// app_cmd WRITE plus one app_wdf beat per beat address.
module mig_write_packer
    import mig_write_packer_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int WORD_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    init_calib_complete,
    input  logic [63:0]             cmd_data,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [WORD_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [2:0]              app_cmd,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic                    app_wdf_wren,
    input  logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_end,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              fsm_state
);

    localparam int LANES      = DATA_WIDTH / WORD_WIDTH;
    localparam int LANE_BITS  = $clog2(LANES);
    localparam int MASK_W     = DATA_WIDTH / 8;
    localparam int WORD_BYTES = WORD_WIDTH / 8;

    // Handshake rule for every port pair here: a transfer happens on a rising
    // edge where valid (or en/wren) and ready (or rdy) are both high.

    wp_state_t             state, state_next;
    mem_wcmd_t             cur;
    logic [DATA_WIDTH-1:0] pack_data;
    logic [MASK_W-1:0]     pack_mask;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  cmd_ok, data_ok;
    logic                  done_q;
    logic [LANE_BITS-1:0]  lane;
    logic                  cmd_fire, word_fire, beat_done;

    assign lane = cur.addr[LANE_BITS-1:0];

    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        cmd_fire     = 1'b0;
        word_fire    = 1'b0;
        beat_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Gated by reset_n so cmd_ready reads 0 while reset is held.
                cmd_ready = init_calib_complete && reset_n;
                cmd_fire  = cmd_valid && cmd_ready;
                if (cmd_fire && (cmd_data[31:0] != 32'd0))
                    state_next = ST_FILL;
            end
            ST_FILL: begin
                wr_ready  = 1'b1;
                word_fire = wr_valid;
                if (word_fire && ((lane == LANE_BITS'(LANES - 1)) || (cur.len == 32'd1)))
                    state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                app_en       = !cmd_ok;
                app_wdf_wren = !data_ok;
                beat_done    = (cmd_ok || app_rdy) && (data_ok || app_wdf_rdy);
                if (beat_done)
                    state_next = (cur.len == 32'd0) ? ST_IDLE : ST_FILL;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cur       <= '0;
            pack_data <= '0;
            pack_mask <= '1;
            beat_addr <= '0;
            cmd_ok    <= 1'b0;
            data_ok   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            if (cmd_fire) begin
                cur <= mem_wcmd_t'(cmd_data);
                if (cmd_data[31:0] == 32'd0)
                    done_q <= 1'b1;
            end
            if (word_fire) begin
                pack_data[lane*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
                pack_mask[lane*WORD_BYTES +: WORD_BYTES] <= '0;
                // A fully set mask means this is the first word of the beat.
                if (pack_mask == '1)
                    beat_addr <= ADDR_WIDTH'({cur.addr >> LANE_BITS, 3'b000});
                cur.addr <= cur.addr + 32'd1;
                cur.len  <= cur.len - 32'd1;
            end
            if (state == ST_ISSUE) begin
                if (beat_done) begin
                    cmd_ok    <= 1'b0;
                    data_ok   <= 1'b0;
                    pack_mask <= '1;
                    pack_data <= '0;
                    if (cur.len == 32'd0)
                        done_q <= 1'b1;
                end else begin
                    if (app_rdy)
                        cmd_ok <= 1'b1;
                    if (app_wdf_rdy)
                        data_ok <= 1'b1;
                end
            end
        end
    end

    assign app_cmd      = APP_CMD_WRITE;
    assign app_addr     = beat_addr;
    assign app_wdf_data = pack_data;
    assign app_wdf_mask = pack_mask;
    assign app_wdf_end  = app_wdf_wren;
    assign busy         = (state != ST_IDLE);
    assign done         = done_q;
    assign fsm_state    = state;

endmodule

// File: tb/tb_mig_write_packer.sv
// Randomized and directed bench for mig_write_packer against a beat-level
// reference model built from word addresses.
module tb_mig_write_packer;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         init_calib_complete = 1'b0;
    logic [63:0]  cmd_data = '0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  wr_data = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic         app_en;
    logic         app_rdy = 1'b0;
    logic [2:0]   app_cmd;
    logic [27:0]  app_addr;
    logic         app_wdf_wren;
    logic         app_wdf_rdy = 1'b0;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_end;
    logic         busy;
    logic         done;
    logic [1:0]   fsm_state;

    mig_write_packer dut (
        .clk(clk), .reset_n(reset_n), .init_calib_complete(init_calib_complete),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .app_en(app_en), .app_rdy(app_rdy), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_wren(app_wdf_wren), .app_wdf_rdy(app_wdf_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_end(app_wdf_end), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int en_cycles = 0;
    int wren_cycles = 0;
    int done_count = 0;
    int cmds_done = 0;
    bit rand_rdy = 1'b0;
    bit force_app_rdy = 1'b1;
    bit force_wdf_rdy = 1'b1;

    logic [27:0]  exp_addr_q[$];
    logic [127:0] exp_data_q[$];
    logic [15:0]  exp_mask_q[$];
    logic [31:0]  cur_words[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: each word lands in beat (addr>>2) lane addr[1:0]; a beat closes
    // at lane 3 or at the last word of the command.
    task automatic model_cmd(input logic [31:0] addr, input int len);
        logic [127:0] d;
        logic [15:0]  m;
        logic [31:0]  wa;
        int           ln;
        d = '0;
        m = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            wa = addr + 32'(i);
            ln = int'(wa[1:0]);
            if (i == 0 || ln == 0) begin
                d = '0;
                m = 16'hFFFF;
                exp_addr_q.push_back(28'((wa >> 2) << 3));
            end
            d[ln*32 +: 32] = cur_words[i];
            m[ln*4 +: 4]   = 4'h0;
            if (ln == 3 || i == len - 1) begin
                exp_data_q.push_back(d);
                exp_mask_q.push_back(m);
            end
        end
    endtask

    task automatic fill_words(input int n, input bit seq);
        cur_words.delete();
        for (int i = 0; i < n; i++)
            cur_words.push_back(seq ? 32'(i + 1) : $urandom);
    endtask

    task automatic drive_cmd(input logic [31:0] addr, input logic [31:0] len,
                             input int nwords, input int gap_max);
        int k;
        int n;
        cmd_data  = {addr, len};
        cmd_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            check("cmd_accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        if (len == 0) begin
            @(negedge clk);
            check("len0_done", done, 1'b1);
        end
        for (int i = 0; i < nwords; i++) begin
            n = $urandom_range(0, gap_max);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
            wr_data  = cur_words[i];
            wr_valid = 1'b1;
            k = 0;
            @(negedge clk);
            while (!wr_ready && k < 500) begin
                @(negedge clk);
                k++;
            end
            if (!wr_ready) begin
                check("wr_accept_timeout", 1'b0, 1'b1);
                wr_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 wr_valid = 1'b0;
        end
    endtask

    task automatic finish_cmd(input logic [31:0] len);
        int k;
        if (len != 0) begin
            k = 0;
            @(negedge clk);
            while (!done && k < 400) begin
                @(negedge clk);
                k++;
            end
            check("done_seen", done, 1'b1);
        end
        cmds_done++;
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("beats_left_addr", 128'(exp_addr_q.size()), 128'd0);
        check("beats_left_data", 128'(exp_data_q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [31:0] addr, input int len, input int gap_max);
        fill_words(len, 1'b0);
        model_cmd(addr, len);
        drive_cmd(addr, 32'(len), len, gap_max);
        finish_cmd(32'(len));
    endtask

    // Ready generator: updates just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) begin
                app_rdy     = ($urandom_range(0, 3) != 0);
                app_wdf_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                app_rdy     = force_app_rdy;
                app_wdf_rdy = force_wdf_rdy;
            end
        end
    end

    // Per-cycle output checker against the model queues.
    initial begin
        bit           prev_issue;
        logic [171:0] prev_vals;
        prev_issue = 1'b0;
        prev_vals  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_issue = 1'b0;
            end else begin
                check("wdf_end", app_wdf_end, app_wdf_wren);
                if (app_en)
                    check("app_cmd", app_cmd, 3'b000);
                if (app_en || app_wdf_wren) begin
                    check("issue_wr_ready", wr_ready, 1'b0);
                    check("issue_busy", busy, 1'b1);
                    if (prev_issue)
                        check("issue_stable", {app_addr, app_wdf_data, app_wdf_mask}, prev_vals);
                end
                if (app_en && app_rdy) begin
                    if (exp_addr_q.size() == 0)
                        check("unexpected_app_en", 1'b1, 1'b0);
                    else
                        check("app_addr", app_addr, exp_addr_q.pop_front());
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    if (exp_data_q.size() == 0) begin
                        check("unexpected_wren", 1'b1, 1'b0);
                    end else begin
                        check("wdf_data", app_wdf_data, exp_data_q.pop_front());
                        check("wdf_mask", app_wdf_mask, exp_mask_q.pop_front());
                    end
                end
                if (app_en) en_cycles++;
                if (app_wdf_wren) wren_cycles++;
                if (done) done_count++;
                prev_vals  = {app_addr, app_wdf_data, app_wdf_mask};
                prev_issue = (app_en || app_wdf_wren) &&
                             !((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy));
            end
        end
    end

    initial begin
        int e0;
        int w0;
        logic [31:0] a;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_ctl", {app_en, app_wdf_wren, app_wdf_end, busy, done, cmd_ready, wr_ready}, 7'd0);
        check("reset_mask", app_wdf_mask, 16'hFFFF);
        check("reset_data", app_wdf_data, 128'd0);
        check("reset_addr", app_addr, 28'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Calibration gates command acceptance
        cmd_data  = {32'h20, 32'd0};
        cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("calib_gate", cmd_ready, 1'b0);
        end
        @(posedge clk);
        #1 init_calib_complete = 1'b1;
        @(negedge clk);
        check("calib_accept", cmd_ready, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("calib_len0_done", done, 1'b1);
        finish_cmd(32'd0);

        // Aligned 8-word command, words 1..8, readies high
        rand_rdy = 1'b0;
        force_app_rdy = 1'b1;
        force_wdf_rdy = 1'b1;
        fill_words(8, 1'b1);
        model_cmd(32'h100, 8);
        check("pin_t1_addr0", exp_addr_q[0], 28'h200);
        check("pin_t1_addr1", exp_addr_q[1], 28'h208);
        check("pin_t1_data0", exp_data_q[0], 128'h00000004_00000003_00000002_00000001);
        check("pin_t1_mask0", exp_mask_q[0], 16'h0000);
        e0 = done_count;
        drive_cmd(32'h100, 32'd8, 8, 0);
        finish_cmd(32'd8);
        check("t1_done_pulses", 128'(done_count - e0), 128'd1);

        // Unaligned start and end
        fill_words(2, 1'b0);
        model_cmd(32'h103, 2);
        check("pin_t2_addr0", exp_addr_q[0], 28'h200);
        check("pin_t2_mask0", exp_mask_q[0], 16'h0FFF);
        check("pin_t2_lane3", exp_data_q[0][127:96], cur_words[0]);
        check("pin_t2_addr1", exp_addr_q[1], 28'h208);
        check("pin_t2_mask1", exp_mask_q[1], 16'hFFF0);
        check("pin_t2_lane0", exp_data_q[1][31:0], cur_words[1]);
        drive_cmd(32'h103, 32'd2, 2, 1);
        finish_cmd(32'd2);

        // app_rdy low for 10 issue cycles, data side ready
        force_app_rdy = 1'b0;
        force_wdf_rdy = 1'b1;
        e0 = en_cycles;
        w0 = wren_cycles;
        fill_words(4, 1'b0);
        model_cmd(32'h0, 4);
        drive_cmd(32'h0, 32'd4, 4, 0);
        repeat (10) @(posedge clk);
        #1 force_app_rdy = 1'b1;
        finish_cmd(32'd4);
        check("t3_en_cycles", 128'(en_cycles - e0), 128'd11);
        check("t3_wren_cycles", 128'(wren_cycles - w0), 128'd1);

        // Zero-length command issues nothing
        e0 = en_cycles;
        w0 = wren_cycles;
        run_cmd(32'h55, 0, 0);
        check("t4_no_en", 128'(en_cycles - e0), 128'd0);
        check("t4_no_wren", 128'(wren_cycles - w0), 128'd0);

        // Reset after 2 of 4 words, then a clean command
        fill_words(4, 1'b0);
        drive_cmd(32'h0, 32'd4, 2, 0);
        reset_n = 1'b0;
        #1;
        check("t6_reset_ctl", {app_en, app_wdf_wren, app_wdf_end, busy, done, cmd_ready, wr_ready}, 7'd0);
        check("t6_reset_mask", app_wdf_mask, 16'hFFFF);
        check("t6_reset_data", app_wdf_data, 128'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_quiet", {app_en, app_wdf_wren}, 2'b00);
        end
        @(posedge clk);
        #1;
        run_cmd(32'h40, 4, 0);

        // Randomized commands, including address wrap
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 4) == 0)
                a = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            else
                a = $urandom;
            run_cmd(a, $urandom_range(0, 12), 2);
        end

        check("total_done_pulses", 128'(done_count), 128'(cmds_done));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
